ddr_rd_sum: RTL and testbench

- AXI4 full read master that streams a contiguous DDR region and accumulates a 32-bit checksum for the DDR bandwidth test.
- Sits directly downstream of the AXI-Lite register slave:
  - Consumes its START and DDR base-address registers.
  - Returns the running sum through the slave's partial-sum readback register.
- Issues NUM_BURSTS incrementing bursts, one burst outstanding at a time.
- Exposes busy, done and error status.

---
 rtl/ddr_rd_sum.sv | 166 ++++++++++++++++
 tb/tb_ddr_rd_sum.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rd_sum.sv
// AXI4 read master that sweeps a contiguous DDR region one burst at a time
// and keeps a wrap-around 32-bit sum of every 32-bit word it reads.
module ddr_rd_sum #(
  parameter int DATA_WIDTH = 64,
  parameter int BURST_LEN  = 16,
  parameter int NUM_BURSTS = 1024
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  start,
  input  logic [31:0]           base_addr,
  output logic [31:0]           partial_sum,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);
  localparam int LANES       = DATA_WIDTH / 32;
  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int BURST_BYTES = BURST_LEN * BYTES;
  localparam int ALIGN_BITS  = $clog2(BURST_BYTES);

  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ALIGN_BITS) - 32'd1);
  localparam logic [31:0] ADDR_STEP  = 32'(BURST_BYTES);
  localparam logic [8:0]  LAST_BEAT  = 9'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        start_q;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] sum_q, sum_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;

  logic [31:0] lane_sum;
  logic        start_edge;
  logic        beat;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + m_axi_rdata[i*32 +: 32];
  end

  assign start_edge = start & ~start_q;
  assign beat       = m_axi_rvalid & rready_q;

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    sum_d       = sum_q;
    burst_cnt_d = burst_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          araddr_d    = base_addr & ALIGN_MASK;
          sum_d       = '0;
          burst_cnt_d = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
          arvalid_d   = 1'b1;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arvalid_q && m_axi_arready) begin
          arvalid_d  = 1'b0;
          beat_cnt_d = '0;
          rready_d   = 1'b1;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (beat) begin
          sum_d      = sum_q + lane_sum;
          beat_cnt_d = beat_cnt_q + 9'd1;
          // A misplaced or missing RLAST is flagged, but the burst always ends on RLAST.
          if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt_q == LAST_BEAT)))
            err_d = 1'b1;
          if (m_axi_rlast) begin
            rready_d = 1'b0;
            if (burst_cnt_q == LAST_BURST) begin
              state_d = S_DONE;
            end else begin
              burst_cnt_d = burst_cnt_q + 16'd1;
              araddr_d    = araddr_q + ADDR_STEP;
              arvalid_d   = 1'b1;
              state_d     = S_ADDR;
            end
          end
        end
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      araddr_q    <= '0;
      sum_q       <= '0;
      burst_cnt_q <= '0;
      beat_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      araddr_q    <= araddr_d;
      sum_q       <= sum_d;
      burst_cnt_q <= burst_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
    end
  end

  assign partial_sum   = sum_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = 8'(BURST_LEN - 1);
  assign m_axi_arsize  = 3'($clog2(BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_ddr_rd_sum.sv
// Bench for ddr_rd_sum: an AXI read slave backed by an address-derived memory,
// a table of directed runs, random runs, and hand-written start/reset sequences.
`timescale 1ns/1ps
module tb_ddr_rd_sum;
  localparam int DW = 64, BL = 4, NB = 2;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] partial_sum, m_axi_araddr;
  logic busy, done, err, m_axi_arvalid, m_axi_rready;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst;
  logic arready, rvalid, rlast;
  logic [DW-1:0] rdata;
  logic [1:0] rresp;

  ddr_rd_sum #(.DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst), .start(start), .base_addr(base),
    .partial_sum(partial_sum), .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
    .m_axi_rready(m_axi_rready));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory content is a function of the byte address: word n of the region is n, or all ones.
  function automatic logic [31:0] word(input logic [31:0] a, input int m);
    return (m == 1) ? 32'hFFFF_FFFF : ((a - 32'h1000_0000) >> 2);
  endfunction

  function automatic logic [31:0] model_sum(input logic [31:0] b, input int m, input int beats);
    logic [31:0] a, s;
    a = b & ~32'h1F;
    s = '0;
    for (int bu = 0; bu < NB; bu++)
      for (int w = 0; w < beats * 2; w++) s = s + word(a + 32'(bu * 32 + w * 4), m);
    return s;
  endfunction

  // Slave configuration (written by main process only)
  int mode = 0, stall_en = 0, err_beat = -1, blen = BL, gbase = 0;
  // Slave state (written by slave process only)
  int gbeat = 0, beat = 0, wait_ar = 0, wait_r = 0;
  logic sbusy = 1'b0, ar_stalled = 1'b0;
  logic [31:0] baddr = '0, stall_addr = '0;
  logic [31:0] got_addr[$];

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    forever begin
      @(negedge clk);
      arready = !sbusy && (wait_ar == 0);
      if (!sbusy && wait_ar > 0) wait_ar--;
      rvalid = sbusy && (wait_r == 0);
      if (sbusy && wait_r > 0) wait_r--;
      rdata = {word(baddr + 32'(8 * beat + 4), mode), word(baddr + 32'(8 * beat), mode)};
      rresp = ((gbeat - gbase) == err_beat) ? 2'b10 : 2'b00;
      rlast = (beat == blen - 1);
      #4;
      if (rst) begin
        sbusy = 1'b0; wait_ar = 0; wait_r = 0; ar_stalled = 1'b0;
      end else begin
        ar_stalled = m_axi_arvalid && !arready;
        if (ar_stalled) stall_addr = m_axi_araddr;
        if (m_axi_arvalid && arready) begin
          got_addr.push_back(m_axi_araddr);
          sbusy = 1'b1; beat = 0; baddr = m_axi_araddr;
          wait_r = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
        if (rvalid && m_axi_rready) begin
          beat++; gbeat++;
          wait_r = stall_en ? int'($urandom_range(0, 5)) : 0;
          if (beat == blen) begin
            sbusy = 1'b0;
            wait_ar = stall_en ? int'($urandom_range(0, 5)) : 0;
          end
        end
      end
    end
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      if (ar_stalled) chk({tag, "_araddr_hold"}, m_axi_araddr, stall_addr);
    end
    chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] b, input int m, input int st,
                     input int eb, input int rb, input logic [31:0] exp_sum,
                     input logic [31:0] exp_a0, input logic exp_err);
    int abase;
    mode = m; stall_en = st; err_beat = eb; blen = rb ? 2 : BL;
    gbase = gbeat; abase = got_addr.size();
    base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    chk({tag, "_done_cleared"}, 32'(done), 32'd0);
    chk({tag, "_err_cleared"}, 32'(err), 32'd0);
    wait_done(tag);
    chk({tag, "_sum"}, partial_sum, exp_sum);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_ar_count"}, 32'(got_addr.size() - abase), 32'(NB));
    if (got_addr.size() - abase == NB) begin
      chk({tag, "_araddr0"}, got_addr[abase], exp_a0);
      chk({tag, "_araddr1"}, got_addr[abase + 1], exp_a0 + 32'h20);
    end
    chk({tag, "_arlen"}, 32'(m_axi_arlen), 32'd3);
    chk({tag, "_arsize"}, 32'(m_axi_arsize), 32'd3);
    chk({tag, "_arburst"}, 32'(m_axi_arburst), 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] base;
    int mode, stall, eb, rb;
    logic [31:0] sum, a0;
    logic err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h1000_0000, 0, 0, -1, 0, 32'd120,        32'h1000_0000, 1'b0};
    tbl[1] = '{32'h1000_0013, 0, 0, -1, 0, 32'd120,        32'h1000_0000, 1'b0};
    tbl[2] = '{32'h1000_0020, 0, 0, -1, 0, 32'd248,        32'h1000_0020, 1'b0};
    tbl[3] = '{32'h1000_0000, 1, 0, -1, 0, 32'hFFFF_FFF0,  32'h1000_0000, 1'b0};
    tbl[4] = '{32'h1000_0000, 0, 1, -1, 0, 32'd120,        32'h1000_0000, 1'b0};
    tbl[5] = '{32'h1000_0000, 0, 0,  2, 0, 32'd120,        32'h1000_0000, 1'b1};
    tbl[6] = '{32'h1000_0000, 0, 0, -1, 1, 32'd44,         32'h1000_0000, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_sum", partial_sum, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("rst_rready", 32'(m_axi_rready), 32'd0);
    chk("rst_araddr", m_axi_araddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run($sformatf("vec%0d", i), tbl[i].base, tbl[i].mode, tbl[i].stall, tbl[i].eb,
          tbl[i].rb, tbl[i].sum, tbl[i].a0, tbl[i].err);

    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      int m, st, eb, rb, beats;
      b = 32'h1000_0000 + 32'($urandom_range(0, 255));
      m = int'($urandom_range(0, 1));
      st = int'($urandom_range(0, 1));
      eb = int'($urandom_range(0, 15));
      rb = ($urandom_range(0, 3) == 0) ? 1 : 0;
      beats = rb ? 2 : BL;
      run($sformatf("rnd%0d", i), b, m, st, eb, rb, model_sum(b, m, beats), b & ~32'h1F,
          (rb == 1) || (eb < NB * beats));
    end

    // start held high: a single run only
    begin
      int abase;
      mode = 0; stall_en = 0; err_beat = -1; blen = BL; abase = got_addr.size();
      base = 32'h1000_0000; start = 1'b1;
      @(negedge clk);
      wait_done("hold");
      repeat (20) @(negedge clk);
      chk("hold_ar_count", 32'(got_addr.size() - abase), 32'(NB));
      chk("hold_busy", 32'(busy), 32'd0);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_sum", partial_sum, 32'd120);
      start = 1'b0;
      @(negedge clk);
    end

    // start toggled while busy is ignored
    begin
      int abase;
      abase = got_addr.size();
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
      end
      wait_done("toggle");
      repeat (5) @(negedge clk);
      chk("toggle_ar_count", 32'(got_addr.size() - abase), 32'(NB));
      chk("toggle_sum", partial_sum, 32'd120);
      chk("toggle_busy", 32'(busy), 32'd0);
    end

    // reset in the middle of the data phase
    begin
      int n = 0;
      gbase = gbeat;
      start = 1'b1; @(negedge clk); start = 1'b0;
      while ((gbeat - gbase) < 2 && n < 200) begin @(negedge clk); n++; end
      chk("midrst_reached_data", 32'(m_axi_rready), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_sum", partial_sum, 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_arvalid", 32'(m_axi_arvalid), 32'd0);
      chk("midrst_rready", 32'(m_axi_rready), 32'd0);
      chk("midrst_araddr", m_axi_araddr, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      run("post_rst", 32'h1000_0000, 0, 0, -1, 0, 32'd120, 32'h1000_0000, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
